// File: rtl/alu_pkg.sv
// Shared opcodes, FSM encodings and opcode legality for the ALU arbiter.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: op_legal = 1'b1;
            default:                               op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way combinational arbiter: round-robin on the last-grant pointer, or fixed priority to requester 0.
module rr_arbiter_2 #(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        // Only a tie needs resolving; last_grant == 1 hands requester 0 the win.
        if (valid == 2'b11) begin
            if (FIXED_PRIORITY || last_grant) grant = 2'b01;
            else                              grant = 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two valid/ready requesters.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int OP_WIDTH       = 3,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic                input_clk,
    input  logic                input_reset_n,
    input  logic                input_req0_valid,
    input  logic [WIDTH-1:0]    input_req0_A,
    input  logic [WIDTH-1:0]    input_req0_B,
    input  logic [OP_WIDTH-1:0] input_req0_ALUOp,
    output logic                output_req0_ready,
    input  logic                input_req1_valid,
    input  logic [WIDTH-1:0]    input_req1_A,
    input  logic [WIDTH-1:0]    input_req1_B,
    input  logic [OP_WIDTH-1:0] input_req1_ALUOp,
    output logic                output_req1_ready,
    output logic                output_rsp0_valid,
    input  logic                input_rsp0_ready,
    output logic                output_rsp1_valid,
    input  logic                input_rsp1_ready,
    output logic [WIDTH-1:0]    output_rsp_result,
    output logic                output_rsp_zero,
    output logic                output_rsp_negative,
    output logic                output_rsp_error,
    output logic [WIDTH-1:0]    output_ALU_A,
    output logic [WIDTH-1:0]    output_ALU_B,
    output logic [OP_WIDTH-1:0] output_ALU_Op,
    input  logic [WIDTH-1:0]    input_ALU_result,
    input  logic                input_ALU_zero,
    input  logic                input_ALU_negative,
    output logic                output_busy
);

    state_t                state, state_nxt;
    logic                  last_grant;
    logic                  gid;
    logic [1:0]            grant;
    logic                  sel;
    logic [WIDTH-1:0]      sel_a, sel_b;
    logic [OP_WIDTH-1:0]   sel_op;
    logic                  sel_legal;
    logic                  accept;
    logic                  rsp_hs;

    rr_arbiter_2 #(.FIXED_PRIORITY(FIXED_PRIORITY)) u_arb (
        .valid      ({input_req1_valid, input_req0_valid}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign sel       = grant[1];
    assign sel_a     = sel ? input_req1_A     : input_req0_A;
    assign sel_b     = sel ? input_req1_B     : input_req0_B;
    assign sel_op    = sel ? input_req1_ALUOp : input_req0_ALUOp;
    assign sel_legal = op_legal(3'(sel_op));
    assign accept    = (state == IDLE) && (|grant);
    assign rsp_hs    = (state == RESP) && (gid ? input_rsp1_ready : input_rsp0_ready);

    always_ff @(posedge input_clk) begin
        if (!input_reset_n) state <= IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|grant) state_nxt = sel_legal ? EXEC : RESP;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        output_req0_ready = input_reset_n && (state == IDLE) && grant[0];
        output_req1_ready = input_reset_n && (state == IDLE) && grant[1];
        output_rsp0_valid = (state == RESP) && !gid;
        output_rsp1_valid = (state == RESP) && gid;
        output_busy       = (state != IDLE);
    end

    // The ALU operand regs double as the latched request, so they only move for legal ops.
    always_ff @(posedge input_clk) begin
        if (!input_reset_n) begin
            last_grant          <= 1'b1;
            gid                 <= 1'b0;
            output_ALU_A        <= '0;
            output_ALU_B        <= '0;
            output_ALU_Op       <= '0;
            output_rsp_result   <= '0;
            output_rsp_zero     <= 1'b0;
            output_rsp_negative <= 1'b0;
            output_rsp_error    <= 1'b0;
        end else begin
            if (accept) begin
                gid <= sel;
                if (sel_legal) begin
                    output_ALU_A  <= sel_a;
                    output_ALU_B  <= sel_b;
                    output_ALU_Op <= sel_op;
                end else begin
                    output_rsp_result   <= '0;
                    output_rsp_zero     <= 1'b0;
                    output_rsp_negative <= 1'b0;
                    output_rsp_error    <= 1'b1;
                end
            end
            if (state == EXEC) begin
                output_rsp_result   <= input_ALU_result;
                output_rsp_zero     <= input_ALU_zero;
                output_rsp_negative <= input_ALU_negative;
                output_rsp_error    <= 1'b0;
            end
            if (rsp_hs) last_grant <= gid;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized bench for alu_arbiter with an external ALU model and a transaction-level reference.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        v0, v1, rdy0, rdy1;
    logic [15:0] a0, b0, a1, b1;
    logic [2:0]  op0, op1;
    logic        rv0, rv1, rr0, rr1;
    logic [15:0] res;
    logic        zero, neg, err, busy;
    logic [15:0] alu_a, alu_b, alu_res;
    logic [2:0]  alu_op;
    logic        alu_z, alu_n;

    int n_assert = 0;
    int n_fail   = 0;
    bit last_tb  = 1'b1;

    alu_arbiter dut (
        .input_clk           (clk),
        .input_reset_n       (rst_n),
        .input_req0_valid    (v0),
        .input_req0_A        (a0),
        .input_req0_B        (b0),
        .input_req0_ALUOp    (op0),
        .output_req0_ready   (rdy0),
        .input_req1_valid    (v1),
        .input_req1_A        (a1),
        .input_req1_B        (b1),
        .input_req1_ALUOp    (op1),
        .output_req1_ready   (rdy1),
        .output_rsp0_valid   (rv0),
        .input_rsp0_ready    (rr0),
        .output_rsp1_valid   (rv1),
        .input_rsp1_ready    (rr1),
        .output_rsp_result   (res),
        .output_rsp_zero     (zero),
        .output_rsp_negative (neg),
        .output_rsp_error    (err),
        .output_ALU_A        (alu_a),
        .output_ALU_B        (alu_b),
        .output_ALU_Op       (alu_op),
        .input_ALU_result    (alu_res),
        .input_ALU_zero      (alu_z),
        .input_ALU_negative  (alu_n),
        .output_busy         (busy)
    );

    function automatic logic [15:0] ref_alu(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        case (op)
            3'b000:  ref_alu = a + b;
            3'b001:  ref_alu = a - b;
            3'b100:  ref_alu = a & b;
            3'b101:  ref_alu = a | b;
            3'b110:  ref_alu = a ^ b;
            default: ref_alu = 16'h0000;
        endcase
    endfunction

    // External ALU stand-in
    assign alu_res = ref_alu(alu_a, alu_b, alu_op);
    assign alu_z   = (alu_res == 16'h0000);
    assign alu_n   = alu_res[15];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit who, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        if (!who) begin v0 = 1'b1; a0 = a; b0 = b; op0 = op; end
        else      begin v1 = 1'b1; a1 = a; b1 = b; op1 = op; end
    endtask

    // One complete transaction for 'who'; the other requester's valid is left as the caller set it.
    task automatic do_op(input bit who, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op, input int stall);
        logic        legal;
        logic [15:0] exp_r;
        logic [15:0] pa, pb;
        logic [2:0]  po;
        legal = (op inside {3'b000, 3'b001, 3'b100, 3'b101, 3'b110});
        exp_r = legal ? ref_alu(a, b, op) : 16'h0000;
        set_req(who, a, b, op);
        #1;
        chkb("ready_winner", who ? rdy1 : rdy0, 1'b1);
        chkb("ready_loser",  who ? rdy0 : rdy1, 1'b0);
        pa = alu_a; pb = alu_b; po = alu_op;
        tick();
        if (!who) v0 = 1'b0; else v1 = 1'b0;
        if (legal) begin
            chkb("exec_busy", busy, 1'b1);
            chkb("exec_no_rsp", rv0 | rv1, 1'b0);
            chkb("exec_no_ready", rdy0 | rdy1, 1'b0);
            chkw("exec_alu_a", alu_a, a);
            chkw("exec_alu_b", alu_b, b);
            chkw("exec_alu_op", {13'd0, alu_op}, {13'd0, op});
            tick();
        end else begin
            chkw("illegal_alu_a", alu_a, pa);
            chkw("illegal_alu_b", alu_b, pb);
            chkw("illegal_alu_op", {13'd0, alu_op}, {13'd0, po});
        end
        chkb("rsp_valid_own",   who ? rv1 : rv0, 1'b1);
        chkb("rsp_valid_other", who ? rv0 : rv1, 1'b0);
        chkw("rsp_result", res, exp_r);
        chkb("rsp_zero", zero, legal && (exp_r == 16'h0000));
        chkb("rsp_negative", neg, exp_r[15]);
        chkb("rsp_error", err, !legal);
        for (int i = 0; i < stall; i++) begin
            // The non-granted response ready must be ignored.
            if (!who) rr1 = 1'b1; else rr0 = 1'b1;
            tick();
            chkb("stall_valid", who ? rv1 : rv0, 1'b1);
            chkw("stall_result", res, exp_r);
            chkb("stall_no_ready", rdy0 | rdy1, 1'b0);
        end
        rr0 = 1'b0; rr1 = 1'b0;
        if (!who) rr0 = 1'b1; else rr1 = 1'b1;
        tick();
        rr0 = 1'b0; rr1 = 1'b0;
        chkb("post_hs_idle", busy, 1'b0);
        chkb("post_hs_no_rsp", rv0 | rv1, 1'b0);
        last_tb = who;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        v0 = 1'b1; v1 = 1'b1;
        tick();
        tick();
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_rsp", rv0 | rv1, 1'b0);
        chkb("rst_ready", rdy0 | rdy1, 1'b0);
        chkw("rst_result", res, 16'h0000);
        chkb("rst_flags", zero | neg | err, 1'b0);
        chkw("rst_alu_a", alu_a, 16'h0000);
        chkw("rst_alu_b", alu_b, 16'h0000);
        chkw("rst_alu_op", {13'd0, alu_op}, 16'h0000);
        v0 = 1'b0; v1 = 1'b0;
        rst_n = 1'b1;
        last_tb = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        v0 = 0; v1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; op0 = 0; op1 = 0;
        rr0 = 0; rr1 = 0;
        do_reset();

        do_op(1'b0, 16'h1234, 16'h5678, 3'b000, 0);

        // Simultaneous requests straight after reset: requester 0 first.
        do_reset();
        set_req(1'b1, 16'hAAAA, 16'h5555, 3'b110);
        do_op(1'b0, 16'h5678, 16'h1234, 3'b001, 0);
        // Requester 0 returns while 1 is still pending: 1 must win this tie.
        set_req(1'b0, 16'h0F0F, 16'h00F1, 3'b000);
        do_op(1'b1, 16'hAAAA, 16'h5555, 3'b110, 0);
        do_op(1'b0, 16'h0F0F, 16'h00F1, 3'b000, 0);

        do_op(1'b1, 16'h0005, 16'h0005, 3'b001, 0);

        // Stalled response with requester 1 waiting.
        set_req(1'b1, 16'h8000, 16'h0001, 3'b001);
        do_op(1'b0, 16'hAAAA, 16'h5555, 3'b100, 3);
        do_op(1'b1, 16'h8000, 16'h0001, 3'b001, 0);

        do_op(1'b0, 16'h1111, 16'h2222, 3'b011, 0);
        do_op(1'b0, 16'hAAAA, 16'h5555, 3'b101, 0);

        // Reset during EXEC drops the operation and restores the pointer.
        set_req(1'b0, 16'h0001, 16'h0002, 3'b000);
        set_req(1'b1, 16'h0003, 16'h0004, 3'b000);
        #1;
        chkb("pre_rst_grant1", rdy1, 1'b1);
        chkb("pre_rst_grant0", rdy0, 1'b0);
        tick();
        v0 = 1'b0; v1 = 1'b0;
        chkb("pre_rst_busy", busy, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        last_tb = 1'b1;
        chkb("midrst_busy", busy, 1'b0);
        chkb("midrst_rsp", rv0 | rv1, 1'b0);
        tick();
        chkb("midrst_rsp_later", rv0 | rv1, 1'b0);
        set_req(1'b1, 16'h0007, 16'h0008, 3'b000);
        do_op(1'b0, 16'h0009, 16'h000A, 3'b000, 0);
        do_op(1'b1, 16'h0007, 16'h0008, 3'b000, 0);

        // Randomized traffic against the transaction-level model.
        for (int k = 0; k < 40; k++) begin
            bit          both, w;
            logic [15:0] ra, rb, oa, ob;
            logic [2:0]  rop, oop;
            int          st;
            both = 1'($urandom_range(0, 1));
            w    = 1'($urandom_range(0, 1));
            ra   = 16'($urandom); rb = 16'($urandom); rop = 3'($urandom_range(0, 7));
            oa   = 16'($urandom); ob = 16'($urandom); oop = 3'($urandom_range(0, 7));
            st   = int'($urandom_range(0, 2));
            if (both) begin
                w = last_tb ? 1'b0 : 1'b1;
                set_req(!w, oa, ob, oop);
            end
            do_op(w, ra, rb, rop, st);
            v0 = 1'b0; v1 = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single 16-bit combinational ALU between two requesters: requester 0 is the multi-cycle datapath control and requester 1 is the branch/address-calculation unit. Each requester uses a valid/ready request and response handshake. The block latches operands, drives the ALU, captures the result, zero and negative flags, and returns them to the granted requester. Arbitration is round-robin, or fixed priority when configured. The ALU itself is instantiated outside this block; this block only drives its inputs and samples its outputs.

Parameters:
WIDTH, 16, operand/result width
OP_WIDTH, 3, ALUOp width
FIXED_PRIORITY, 0, 0 = round-robin; 1 = requester 0 always wins ties

Ports:
input_clk  in  1  clock, rising edge
input_reset_n  in  1  synchronous, active-low reset
input_req0_valid  in  1  requester 0 has an operation
input_req0_A  in  WIDTH  requester 0 operand A
input_req0_B  in  WIDTH  requester 0 operand B
input_req0_ALUOp  in  OP_WIDTH  requester 0 opcode
output_req0_ready  out  1  requester 0 request accepted this cycle
input_req1_valid / input_req1_A / input_req1_B / input_req1_ALUOp / output_req1_ready  same widths and meanings as requester 0
output_rsp0_valid  out  1  response available for requester 0
input_rsp0_ready  in  1  requester 0 takes the response
output_rsp1_valid  out  1  response available for requester 1
input_rsp1_ready  in  1  requester 1 takes the response
output_rsp_result  out  WIDTH  shared result bus, valid only with the asserted rsp*_valid
output_rsp_zero  out  1  result == 0
output_rsp_negative  out  1  result[WIDTH-1]
output_rsp_error  out  1  the operation had an illegal opcode
output_ALU_A  out  WIDTH  to ALU input_A
output_ALU_B  out  WIDTH  to ALU input_B
output_ALU_Op  out  OP_WIDTH  to ALU input_ALUOp
input_ALU_result  in  WIDTH  from ALU output_ALU
input_ALU_zero  in  1  from ALU output_Zero
input_ALU_negative  in  1  from ALU output_negative
output_busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-low.
- Reset values: state = IDLE; all outputs are 0; the last-grant pointer is 1, so requester 0 wins first.
- Legal opcodes: 000 ADD, 001 SUB, 100 AND, 101 OR, 110 XOR. Opcodes 010, 011 and 111 are illegal.

State IDLE:
- Requests are sampled here only. The ready output is combinational and asserted only in IDLE, for the single winner.
- Round-robin: if both requesters are valid, the one not granted last wins.
- Fixed priority: requester 0 wins.
- A single valid requester always wins.
- On the accepting edge, latch A, B, ALUOp and the grant id into internal regs.
- Next state: EXEC if the opcode is legal; RESP with error = 1, result = 0, zero = 0, negative = 0 if illegal. The ALU is not used for an illegal opcode.

State EXEC:
- output_ALU_A, output_ALU_B and output_ALU_Op are driven from the latched regs.
- At the end of the cycle, register input_ALU_result, input_ALU_zero and input_ALU_negative into the response regs, with error = 0.
- Next state: RESP.

State RESP:
- rsp*_valid is asserted for the granted id only. Result and flags stay stable until input_rsp*_ready for that id is high.
- On the handshake: last-grant = grant id, state = IDLE.
- The first new accept can occur in the cycle after the handshake.
- rsp*_ready for the non-granted id is ignored.

Timing and data rules:
- Latency, legal op: accept at cycle N, rsp_valid at N+2, minimum throughput one operation per 3 cycles.
- Latency, illegal op: rsp_valid at N+1.
- ALU outputs hold their last value outside EXEC; no toggling is required.
- Result width is WIDTH; carry/overflow are not reported; wrap-around follows the ALU.

Boundary cases:
- A requester that drops valid in IDLE before being granted: nothing is recorded.
- A requester that raises valid while the arbiter is busy waits; no request is queued.
- A valid held continuously by one requester with the other idle is granted back-to-back, every 3 cycles.
- Reset mid-operation, in any state: the in-flight operation is dropped, no response is produced, and the reset values apply on the next cycle.

Decomposition:
- Package alu_pkg holds:
  - ALUOp localparams: OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b100, OP_OR = 3'b101, OP_XOR = 3'b110.
  - An op-legality function.
  - FSM state encodings: IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2.
- Sub-module rr_arbiter_2: 2-way combinational grant from the valids, the last-grant pointer and FIXED_PRIORITY; one-hot grant output.

Test Plan:
- ADD requester 0, 0x1234 + 0x5678: ready0 high in cycle 0; rsp0_valid in cycle 2; result 0x68AC, zero = 0, negative = 0, error = 0.
- Both requesters valid right after reset: requester 0 SUB 0x5678 − 0x1234 is granted first and returns 0x4444; then requester 1 XOR 0xAAAA ^ 0x5555 returns 0xFFFF, negative = 1. A second simultaneous pair is granted to requester 1 first.
- SUB 0x0005 − 0x0005 from requester 1: result 0x0000, zero = 1, rsp1_valid only (rsp0_valid stays 0).
- Hold rsp0_ready low for 3 cycles after an AND 0xAAAA & 0x5555 (result 0x0000, zero = 1): rsp0_valid and the result stay stable, a pending requester 1 gets no ready, and requester 1 is granted one cycle after the handshake.
- Opcode 3'b011 from requester 0: rsp0_valid at cycle 1, error = 1, result 0, ALU outputs unchanged. Then OR 0xAAAA | 0x5555 gives 0xFFFF, error = 0.
- Assert reset during EXEC: the next cycle has busy = 0, all rsp valids 0, and no response issued. The following simultaneous request is granted to requester 0.
